// File: rtl/rv32_pipeline_cpu_pkg.sv
// Shared encodings, pipeline-register layouts and ALU-control decode for the
// five-stage RV32 subset core.
package rv32_pipeline_cpu_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_XOR = 3'd1,
    ALU_SLL = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_MUL = 3'd5,
    ALU_SRA = 3'd6
  } alu_ctl_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  rd;
  } memwb_t;

  function automatic alu_ctl_e alu_ctl(input alu_op_e op, input logic [2:0] f3,
                                       input logic [6:0] f7);
    alu_ctl = ALU_ADD;
    case (op)
      ALUOP_SUB:   alu_ctl = ALU_SUB;
      ALUOP_ITYPE: if (f3 == F3_SRA) alu_ctl = ALU_SRA;
      ALUOP_RTYPE: begin
        case (f3)
          F3_AND: alu_ctl = ALU_AND;
          F3_XOR: alu_ctl = ALU_XOR;
          F3_SLL: alu_ctl = ALU_SLL;
          F3_ADD: begin
            if (f7 == F7_ALT)      alu_ctl = ALU_SUB;
            else if (f7 == F7_MUL) alu_ctl = ALU_MUL;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/rv32_pipeline_cpu_hazard_forward_unit.sv
// Load-use stall detection and EX-stage operand forwarding selects.
module hazard_forward_unit
  import rv32_pipeline_cpu_pkg::*;
(
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rd_i,
  input  logic [4:0] ifid_rs1_i,
  input  logic [4:0] ifid_rs2_i,
  input  logic [4:0] idex_rs1_i,
  input  logic [4:0] idex_rs2_i,
  input  logic       exmem_reg_write_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_reg_write_i,
  input  logic [4:0] memwb_rd_i,
  output logic       stall_o,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);

  function automatic fwd_sel_e pick(input logic [4:0] rs, input logic exm_we,
                                    input logic [4:0] exm_rd, input logic wb_we,
                                    input logic [4:0] wb_rd);
    pick = FWD_REG;
    if (exm_we && exm_rd != '0 && exm_rd == rs)    pick = FWD_EXMEM;
    else if (wb_we && wb_rd != '0 && wb_rd == rs)  pick = FWD_MEMWB;
  endfunction

  // Stall when the load in EX produces a register the ID instruction names
  always_comb begin
    stall_o = idex_mem_read_i && (idex_rd_i != '0) &&
              ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
    fwd_a_o = pick(idex_rs1_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i);
    fwd_b_o = pick(idex_rs2_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i);
  end

endmodule

// File: rtl/rv32_pipeline_cpu.sv
// Five-stage in-order RV32 subset core with load-use stall, EX forwarding
// and beq resolved in ID.
module rv32_pipeline_cpu
  import rv32_pipeline_cpu_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem    [IMEM_WORDS];
  logic [31:0] regfile [32];
  logic [31:0] dmem    [DMEM_WORDS];

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic        stall, flush;
  fwd_sel_e    fwd_a, fwd_b;
  logic [31:0] wb_data, br_target;
  logic [31:0] id_rv1, id_rv2, imm_i, imm_s, imm_b;
  logic [31:0] ex_a, ex_b, ex_b_fwd, ex_res;

  hazard_forward_unit u_hfu (
    .idex_mem_read_i  (idex_q.mem_read),
    .idex_rd_i        (idex_q.rd),
    .ifid_rs1_i       (ifid_q.inst[19:15]),
    .ifid_rs2_i       (ifid_q.inst[24:20]),
    .idex_rs1_i       (idex_q.rs1),
    .idex_rs2_i       (idex_q.rs2),
    .exmem_reg_write_i(exmem_q.reg_write),
    .exmem_rd_i       (exmem_q.rd),
    .memwb_reg_write_i(memwb_q.reg_write),
    .memwb_rd_i       (memwb_q.rd),
    .stall_o          (stall),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b)
  );

  // Writeback value, shared by the regfile port, ID bypass and MEM/WB forward
  always_comb wb_data = memwb_q.mem_to_reg ? memwb_q.load_data : memwb_q.alu_result;

  // IF: next PC and IF/ID; stall freezes both, a taken beq redirects and squashes
  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    if (!stall) begin
      if (flush) begin
        pc_d   = br_target;
        ifid_d = '0;
      end else if (start_i) begin
        pc_d        = pc_q + 32'd4;
        ifid_d.pc   = pc_q;
        ifid_d.inst = imem[pc_q[IAW+1:2]];
      end else begin
        ifid_d = '0;
      end
    end
  end

  // ID: register read with WB bypass, branch decision, control decode
  always_comb begin
    id_rv1 = regfile[ifid_q.inst[19:15]];
    if (memwb_q.reg_write && memwb_q.rd == ifid_q.inst[19:15]) id_rv1 = wb_data;
    if (ifid_q.inst[19:15] == '0) id_rv1 = '0;
    id_rv2 = regfile[ifid_q.inst[24:20]];
    if (memwb_q.reg_write && memwb_q.rd == ifid_q.inst[24:20]) id_rv2 = wb_data;
    if (ifid_q.inst[24:20] == '0) id_rv2 = '0;

    imm_i = {{20{ifid_q.inst[31]}}, ifid_q.inst[31:20]};
    imm_s = {{20{ifid_q.inst[31]}}, ifid_q.inst[31:25], ifid_q.inst[11:7]};
    imm_b = {{19{ifid_q.inst[31]}}, ifid_q.inst[31], ifid_q.inst[7],
             ifid_q.inst[30:25], ifid_q.inst[11:8], 1'b0};
    br_target = ifid_q.pc + imm_b;
    flush = !stall && (ifid_q.inst[6:0] == OPC_BEQ) && (id_rv1 == id_rv2);

    idex_d         = '0;
    idex_d.rs1_val = id_rv1;
    idex_d.rs2_val = id_rv2;
    idex_d.rs1     = ifid_q.inst[19:15];
    idex_d.rs2     = ifid_q.inst[24:20];
    idex_d.rd      = ifid_q.inst[11:7];
    idex_d.funct3  = ifid_q.inst[14:12];
    idex_d.funct7  = ifid_q.inst[31:25];
    case (ifid_q.inst[6:0])
      OPC_RTYPE: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_op    = ALUOP_RTYPE;
      end
      OPC_IMM: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.alu_op    = ALUOP_ITYPE;
        idex_d.imm       = imm_i;
      end
      OPC_LW: begin
        idex_d.reg_write  = 1'b1;
        idex_d.mem_read   = 1'b1;
        idex_d.mem_to_reg = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.imm        = imm_i;
      end
      OPC_SW: begin
        idex_d.mem_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.imm       = imm_s;
      end
      OPC_BEQ: begin
        idex_d.alu_op = ALUOP_SUB;
        idex_d.imm    = imm_b;
      end
      default: ;
    endcase
    if (stall) idex_d = '0;
  end

  // EX: forwarded operands into the ALU; forwarded rs2 doubles as store data
  always_comb begin
    case (fwd_a)
      FWD_EXMEM: ex_a = exmem_q.alu_result;
      FWD_MEMWB: ex_a = wb_data;
      default:   ex_a = idex_q.rs1_val;
    endcase
    case (fwd_b)
      FWD_EXMEM: ex_b_fwd = exmem_q.alu_result;
      FWD_MEMWB: ex_b_fwd = wb_data;
      default:   ex_b_fwd = idex_q.rs2_val;
    endcase
    ex_b = idex_q.alu_src ? idex_q.imm : ex_b_fwd;
    case (alu_ctl(idex_q.alu_op, idex_q.funct3, idex_q.funct7))
      ALU_AND: ex_res = ex_a & ex_b;
      ALU_XOR: ex_res = ex_a ^ ex_b;
      ALU_SLL: ex_res = ex_a << ex_b[4:0];
      ALU_SUB: ex_res = ex_a - ex_b;
      ALU_MUL: ex_res = ex_a * ex_b;
      ALU_SRA: ex_res = $signed(ex_a) >>> ex_b[4:0];
      default: ex_res = ex_a + ex_b;
    endcase
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.alu_result = ex_res;
    exmem_d.store_data = ex_b_fwd;
    exmem_d.rd         = idex_q.rd;
  end

  // MEM: combinational load read into MEM/WB
  always_comb begin
    memwb_d            = '0;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.alu_result = exmem_q.alu_result;
    memwb_d.load_data  = dmem[exmem_q.alu_result[DAW+1:2]];
    memwb_d.rd         = exmem_q.rd;
  end

  // PC and pipeline registers; reset leaves a bubble in every stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Architectural state has no reset so preloaded contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (memwb_q.reg_write && memwb_q.rd != '0) regfile[memwb_q.rd] <= wb_data;
    if (exmem_q.mem_write) dmem[exmem_q.alu_result[DAW+1:2]] <= exmem_q.store_data;
  end

endmodule

// File: tb/tb_rv32_pipeline_cpu.sv
// Bench for rv32_pipeline_cpu: an in-order instruction-set model plus simple
// stall/branch timing rules predict PC, Stall and Flush every cycle and the
// final register/data-memory state of each directed program.
module tb_rv32_pipeline_cpu;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;

  rv32_pipeline_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;
  int flush_cnt = 0;

  logic [31:0] m_imem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_pc = '0, m_id_inst = '0, m_id_pc = '0, m_ex_inst = '0;
  logic [31:0] prog [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] m_immb(input logic [31:0] in);
    return {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
  endfunction

  // Load in EX whose destination the ID instruction names
  function automatic logic m_stall();
    logic [4:0] rd;
    rd = m_ex_inst[11:7];
    return (m_ex_inst[6:0] == 7'b0000011) && (rd != 5'd0) &&
           (rd == m_id_inst[19:15] || rd == m_id_inst[24:20]);
  endfunction

  function automatic logic m_flush();
    return !m_stall() && (m_id_inst[6:0] == 7'b1100011) &&
           (m_regs[m_id_inst[19:15]] == m_regs[m_id_inst[24:20]]);
  endfunction

  // Architectural effect of one instruction, applied in program order
  task automatic m_exec(input logic [31:0] in);
    logic [31:0] a, b, r, immi, imms, addr;
    logic wr;
    a    = m_regs[in[19:15]];
    b    = m_regs[in[24:20]];
    immi = {{20{in[31]}}, in[31:20]};
    imms = {{20{in[31]}}, in[31:25], in[11:7]};
    r    = '0;
    wr   = 1'b0;
    case (in[6:0])
      7'b0110011: begin
        wr = 1'b1;
        case ({in[31:25], in[14:12]})
          {7'h00, 3'd7}: r = a & b;
          {7'h00, 3'd4}: r = a ^ b;
          {7'h00, 3'd1}: r = a << b[4:0];
          {7'h00, 3'd0}: r = a + b;
          {7'h20, 3'd0}: r = a - b;
          {7'h01, 3'd0}: r = a * b;
          default:       wr = 1'b0;
        endcase
      end
      7'b0010011: begin
        wr = 1'b1;
        if (in[14:12] == 3'd0)      r = a + immi;
        else if (in[14:12] == 3'd5) r = $signed(a) >>> immi[4:0];
        else                        wr = 1'b0;
      end
      7'b0000011: begin
        addr = a + immi;
        r    = m_dmem[addr[6:2]];
        wr   = 1'b1;
      end
      7'b0100011: begin
        addr = a + imms;
        m_dmem[addr[6:2]] = b;
      end
      default: ;
    endcase
    if (wr && in[11:7] != 5'd0) m_regs[in[11:7]] = r;
  endtask

  // Model pipeline front end: fetch, stall and branch redirect timing
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc      <= '0;
      m_id_inst <= '0;
      m_id_pc   <= '0;
      m_ex_inst <= '0;
    end else if (m_stall()) begin
      m_ex_inst <= '0;
    end else begin
      m_ex_inst <= m_id_inst;
      if (m_flush()) begin
        m_pc      <= m_id_pc + m_immb(m_id_inst);
        m_id_inst <= '0;
        m_id_pc   <= '0;
      end else if (start) begin
        m_id_inst <= m_imem[m_pc[9:2]];
        m_id_pc   <= m_pc;
        m_pc      <= m_pc + 32'd4;
      end else begin
        m_id_inst <= '0;
        m_id_pc   <= '0;
      end
      m_exec(m_id_inst);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("pc", dut.pc_q, m_pc);
    check("stall", {31'b0, dut.stall}, {31'b0, m_stall()});
    check("flush", {31'b0, dut.flush}, {31'b0, m_flush()});
    if (dut.stall && dut.ifid_q.inst[6:0] != 7'b1100011) stall_cnt++;
    if (dut.flush) flush_cnt++;
  end

  task automatic load_prog();
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = '0;
      m_imem[i]   = '0;
    end
    foreach (prog[i]) begin
      dut.imem[i] = prog[i];
      m_imem[i]   = prog[i];
    end
  endtask

  task automatic restart(input int cycles);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    load_prog();
    stall_cnt = 0;
    flush_cnt = 0;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic compare_state();
    for (int i = 0; i < 32; i++) check($sformatf("reg_x%0d", i), dut.regfile[i], m_regs[i]);
    for (int i = 0; i < 32; i++) check($sformatf("dmem_%0d", i), dut.dmem[i], m_dmem[i]);
  endtask

  initial begin
    #1 rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_regs[i]       = (i >= 12) ? 32'h0101_0101 * i : 32'h0;
      dut.regfile[i]  = m_regs[i];
      m_dmem[i]       = (i == 0) ? 32'd5 : (i == 1) ? 32'd0 : 32'hD000_0000 + i;
      dut.dmem[i]     = m_dmem[i];
    end
    prog = {};
    load_prog();
    #1;
    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_stall", {31'b0, dut.stall}, 32'h0);

    // Empty IMEM: PC steps by 4, nothing else changes
    restart(10);
    check("nop_pc", dut.pc_q, 32'd40);
    check("nop_stalls", 32'(stall_cnt), 32'd0);
    check("nop_flushes", 32'(flush_cnt), 32'd0);
    check("nop_x12", dut.regfile[12], 32'h0C0C_0C0C);
    compare_state();

    // Back-to-back dependent ALU ops through both forward paths
    prog = {enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'b0010011),
            enc_i(12'd3, 5'd1, 3'd0, 5'd2, 7'b0010011),
            enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)};
    restart(10);
    check("fwd_x1", dut.regfile[1], 32'd7);
    check("fwd_x2", dut.regfile[2], 32'd10);
    check("fwd_x3", dut.regfile[3], 32'd17);
    check("fwd_pc", dut.pc_q, 32'd40);
    check("fwd_stalls", 32'(stall_cnt), 32'd0);
    compare_state();

    // Load-use: one stall, PC holds once
    prog = {enc_i(12'd0, 5'd0, 3'b010, 5'd4, 7'b0000011),
            enc_i(12'd1, 5'd4, 3'd0, 5'd5, 7'b0010011)};
    restart(10);
    check("lu_x4", dut.regfile[4], 32'd5);
    check("lu_x5", dut.regfile[5], 32'd6);
    check("lu_pc", dut.pc_q, 32'd36);
    check("lu_stalls", 32'(stall_cnt), 32'd1);
    compare_state();

    // srai / mul / sub and a store of a freshly produced value
    prog = {enc_i(12'hFF8, 5'd0, 3'd0, 5'd6, 7'b0010011),
            enc_i(12'h401, 5'd6, 3'd5, 5'd7, 7'b0010011),
            enc_r(7'h01, 5'd6, 5'd6, 3'd0, 5'd8),
            enc_r(7'h20, 5'd6, 5'd0, 3'd0, 5'd9),
            enc_s(12'd4, 5'd8, 5'd0)};
    restart(12);
    check("alu_x6", dut.regfile[6], 32'hFFFF_FFF8);
    check("alu_x7", dut.regfile[7], 32'hFFFF_FFFC);
    check("alu_x8", dut.regfile[8], 32'd64);
    check("alu_x9", dut.regfile[9], 32'd8);
    check("alu_dmem1", dut.dmem[1], 32'd64);
    compare_state();

    // Taken beq squashes the next fetch
    prog = {enc_b(13'd8, 5'd0, 5'd0),
            enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'b0010011),
            enc_i(12'd2, 5'd0, 3'd0, 5'd11, 7'b0010011)};
    restart(8);
    check("br_flushes", 32'(flush_cnt), 32'd1);
    check("br_x10", dut.regfile[10], 32'd0);
    check("br_x11", dut.regfile[11], 32'd2);
    check("br_pc", dut.pc_q, 32'd32);
    compare_state();

    // Asynchronous reset mid-run keeps architectural state
    prog = {enc_i(12'd99, 5'd0, 3'd0, 5'd13, 7'b0010011)};
    restart(6);
    check("ar_pc_before", dut.pc_q, 32'd24);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_pc_async", dut.pc_q, 32'h0);
    check("ar_x13", dut.regfile[13], 32'd99);
    check("ar_dmem1", dut.dmem[1], 32'd64);
    compare_state();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_pipeline_cpu.md
Name: rv32_pipeline_cpu

Overview:
- 5-stage in-order RV32 subset processor: IF, ID, EX, MEM, WB.
- Contains the PC, a 256-word instruction memory, a 32x32 register file, a 32-word data memory, and the pipeline registers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Load-use hazards are resolved by stalling; all other data hazards by forwarding.
- beq is resolved in ID, with a one-slot flush when taken.
- Top-level block; memories and registers are preloaded hierarchically by the bench.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; word-addressed by PC[31:2].
- DMEM_WORDS, 32, data memory depth in 32-bit words; word-addressed by addr[31:2].

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  run enable; PC advances only while 1.

Behaviour:
- Reset: PC=0 and all pipeline-register fields=0 (a bubble). Reset does not clear the register file or either memory (both are bench-preloaded).
- Instruction set:
  - R-type, opcode 0110011: and, xor, sll, add, sub (funct7 0100000), mul (funct7 0000001, low 32 bits of the product).
  - addi and srai, opcode 0010011; srai uses funct3 101, funct7 0100000, shamt = imm[4:0], arithmetic shift.
  - lw 0000011, sw 0100011, beq 1100011.
  - All-zero instruction = nop: no register or memory write.
- Immediates: I-type sign-extended imm[11:0]; S-type {inst[31:25], inst[11:7]}; B-type offset = sign-extended 12-bit imm shifted left 1, added to the ID-stage PC.
- IF: instruction = IMEM[PC>>2]; next PC = PC+4.
  - Taken branch: next PC = branch target.
  - Stall: PC and IF/ID hold.
  - start_i=0: PC holds.
- ID:
  - Register file reads are combinational.
  - A same-cycle WB write to the register being read is bypassed to the ID read port.
  - x0 reads 0 and is never written.
  - beq compares the two ID read values; there is no forwarding into ID.
  - Taken beq: Flush=1, IF/ID is zeroed on the next edge (one-cycle penalty).
- Hazard detection: if ID/EX.MemRead and ID/EX.rd≠0 and ID/EX.rd equals IF/ID rs1 or rs2, then:
  - Stall=1: PC and IF/ID hold.
  - ID/EX receives zeroed control (bubble).
  - Stall has priority over the branch decision in that cycle.
- Forwarding in EX, per operand:
  - EX/MEM (RegWrite, rd≠0, rd match) has priority over MEM/WB.
  - Otherwise the ID/EX register value is used.
  - The forwarded rs2 value is also the store data.
- MEM: lw reads DMEM combinationally; sw writes DMEM on posedge.
- WB: RegWrite writes ALU result or load data (MemtoReg) on posedge.
- Arithmetic: 32-bit wrap-around, no exceptions. Shifts use operand[4:0].
- Internal observable signals:
  - Stall = hazard-unit stall output.
  - Flush = branch-taken output.
  - Named so the bench can count them: a stall is counted only when the ID instruction is not beq.

Decomposition:
- Shared package:
  - opcode constants;
  - funct3/funct7 values;
  - 2-bit ALUOp encoding;
  - ALU-control codes (AND, XOR, SLL, ADD, SUB, MUL, SRA);
  - forwarding-select encoding (00 reg, 10 EX/MEM, 01 MEM/WB).
- One natural sub-module: hazard_forward_unit. It combines load-use detection and forwarding-select logic.
- Memories, register file and pipeline registers stay as named internal arrays/regs in the CPU.

Test Plan:
- Reset then start, IMEM all zeros: PC = 0, 4, 8, … each cycle; no register or memory changes; Stall = Flush = 0.
- addi x1,x0,7; addi x2,x1,3; add x3,x1,x2 (back-to-back): x1=7, x2=10, x3=17 via EX/MEM and MEM/WB forwarding; no stalls.
- DMEM[0]=5; lw x4,0(x0); addi x5,x4,1: exactly one stall; x5=6; PC holds one cycle.
- addi x6,x0,-8; srai x7,x6,1; mul x8,x6,x6; sub x9,x0,x6; sw x8,4(x0): x7=-4, x8=64, x9=8, DMEM[1]=64.
- beq x0,x0,+8 followed by addi x10,x0,1; addi x11,x0,2: flush count 1; x10 stays 0; x11=2.
- Assert rst_i mid-run: PC returns to 0 immediately, without waiting for a clock edge; the register file and DMEM keep their prior contents.
